cache_axi_bridge: RTL and testbench
===================================

Name: cache_axi_bridge

Overview:
- Downstream memory-side neighbour of the data cache.
- Accepts line-granular refill (read) and writeback (write) requests from the cache, then executes them as single AXI4 INCR bursts toward memory.
- Writeback data is staged from the cache into an internal line buffer. Refill data is buffered and replayed to the cache one beat per cycle.
- Sits between the dcache and the AXI interconnect.

Parameters:
- BEATS, 8, beats per cache line (line = BEATS*8 bytes); power of two, 2..16.
- AXI_ID, 0, constant 4-bit ID driven on AWID/ARID.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ready  out  1  bridge idle, may accept req
- req  in  1  start transaction; sampled only when ready=1
- rw  in  1  0=refill read, 1=writeback write
- addr  in  64  line address; low log2(BEATS*8) bits ignored and forced to 0
- fifo_wen  in  1  writeback data beat valid (write path only)
- fifo_data  in  64  writeback data beat
- done  out  1  transaction-complete strobe / refill replay-beat valid
- data_o  out  64  refill beat during replay
- beat_idx  out  4  index of the beat currently on data_o
- bus_err  out  1  see Optional Feature
- m_awaddr out 64, m_awlen out 8, m_awsize out 3, m_awburst out 2, m_awid out 4, m_awvalid out 1, m_awready in 1
- m_wdata out 64, m_wstrb out 8, m_wlast out 1, m_wvalid out 1, m_wready in 1
- m_bresp in 2, m_bvalid in 1, m_bready out 1
- m_araddr out 64, m_arlen out 8, m_arsize out 3, m_arburst out 2, m_arid out 4, m_arvalid out 1, m_arready in 1
- m_rdata in 64, m_rresp in 2, m_rlast in 1, m_rvalid in 1, m_rready out 1

Behaviour:
- Reset:
  - state=IDLE, ready=1.
  - All valid/ready/done/bus_err outputs=0; data_o=0; beat_idx=0.
  - Beat counter cleared; line buffer contents undefined.
  - Reset mid-burst abandons the transaction with no AXI cleanup; the interconnect is reset together with the bridge.
- Constant AXI fields: len=BEATS-1, size=3, burst=INCR(2'b01), wstrb=8'hFF, id=AXI_ID.
- States: IDLE, WCOLLECT, AW, WDATA, BRESP, AR, RDATA, REPLAY.
- IDLE:
  - On req & ready: latch aligned addr, ready->0 next cycle.
  - rw=1 -> WCOLLECT. rw=0 -> AR.
- WCOLLECT:
  - Each fifo_wen cycle writes fifo_data to buf[cnt]; cnt++.
  - After BEATS beats -> AW.
  - fifo_wen is ignored outside WCOLLECT.
  - fifo_wen may arrive in the same cycle as req; it is captured as beat 0.
- AW: awvalid=1 and held stable until awready; the handshake cycle -> WDATA with cnt=0.
- WDATA:
  - wvalid=1, wdata=buf[cnt], wlast=(cnt==BEATS-1).
  - cnt advances only on wvalid&wready.
  - Last handshake -> BRESP.
- BRESP:
  - bready=1.
  - On bvalid: done=1 for exactly one cycle, then IDLE with ready=1 the following cycle.
- AR: arvalid=1 until arready -> RDATA, cnt=0.
- RDATA:
  - rready=1; each rvalid stores rdata into buf[cnt], cnt++.
  - Entry with rlast, or when cnt reaches BEATS -> REPLAY, cnt=0.
  - If rlast arrives early, the remaining beats are undefined.
  - Extra beats after BEATS are dropped.
- REPLAY:
  - For BEATS consecutive cycles: done=1, data_o=buf[i], beat_idx=i, for i=0..BEATS-1.
  - Then IDLE.
  - The cache must accept one beat per cycle (no backpressure).
- Latency:
  - Write: done occurs 1 cycle after the bvalid handshake.
  - Read: first replay beat occurs 1 cycle after the rlast handshake.
- req while ready=0 is ignored (the requester holds req until it sees ready).
- Never drives AW and AR concurrently; one outstanding transaction max.
- Address bits above 63 wrap; no 4KB-crossing check (line-aligned bursts never cross).

Optional Feature:
- Macro: BRIDGE_RESP_CHECK_EN.
- Defined:
  - Any m_bresp or m_rresp != 2'b00 during a handshake sets bus_err sticky.
  - bus_err clears only on rst.
  - The transaction still completes normally.
- Undefined: responses are ignored; bus_err is tied to 0.

Test Plan:
- Refill: req rw=0 addr=0x8000_1234 -> araddr=0x8000_1200, arlen=7. Memory returns 0x11..0x88 -> done high 8 cycles, data_o 0x11..0x88, beat_idx 0..7, ready=1 afterwards.
- Writeback: req rw=1 addr=0x8000_0040, then 8 fifo_wen beats 0xA0..0xA7 with awready delayed 3 cycles -> awaddr=0x8000_0040; wdata 0xA0..0xA7 with wlast on beat 7; single-cycle done after bvalid.
- wready toggling every other cycle -> no beat lost or duplicated; exactly 8 W handshakes.
- rst asserted during RDATA beat 4 -> next cycle ready=1, rready=0, done=0; a new refill completes correctly.
- With BRIDGE_RESP_CHECK_EN: rresp=2'b10 on beat 3 -> bus_err=1 and stays 1 across the following writeback; replay still emits 8 beats.
- req held while busy plus a spurious fifo_wen in RDATA -> no second AR issued; buffer unaffected.

Source files
------------

// File: rtl/cache_axi_bridge.sv
// Line-granular refill/writeback bridge between the data cache and an AXI4 memory port.
// Optional macro BRIDGE_RESP_CHECK_EN enables a sticky bus_err flag on non-OKAY responses.
module cache_axi_bridge #(
    parameter int         BEATS  = 8,
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ready,
    input  logic        req,
    input  logic        rw,
    input  logic [63:0] addr,
    input  logic        fifo_wen,
    input  logic [63:0] fifo_data,
    output logic        done,
    output logic [63:0] data_o,
    output logic [3:0]  beat_idx,
    output logic        bus_err,
    output logic [63:0] m_awaddr,
    output logic [7:0]  m_awlen,
    output logic [2:0]  m_awsize,
    output logic [1:0]  m_awburst,
    output logic [3:0]  m_awid,
    output logic        m_awvalid,
    input  logic        m_awready,
    output logic [63:0] m_wdata,
    output logic [7:0]  m_wstrb,
    output logic        m_wlast,
    output logic        m_wvalid,
    input  logic        m_wready,
    input  logic [1:0]  m_bresp,
    input  logic        m_bvalid,
    output logic        m_bready,
    output logic [63:0] m_araddr,
    output logic [7:0]  m_arlen,
    output logic [2:0]  m_arsize,
    output logic [1:0]  m_arburst,
    output logic [3:0]  m_arid,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [63:0] m_rdata,
    input  logic [1:0]  m_rresp,
    input  logic        m_rlast,
    input  logic        m_rvalid,
    output logic        m_rready
);

    localparam int          IW         = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [63:0] ALIGN_MASK = ~(64'(BEATS * 8) - 64'd1);
    localparam logic [3:0]  LAST       = 4'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE, WCOLLECT, AW, WDATA, BRESP, AR, RDATA, REPLAY
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [63:0]   addr_q, addr_d;
    logic          done_q, done_d;
    logic [63:0]   buf_q [BEATS];
    logic          buf_we;
    logic [63:0]   buf_wdata;
    logic [IW-1:0] idx;

    assign idx = cnt_q[IW-1:0];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        done_d    = 1'b0;
        buf_we    = 1'b0;
        buf_wdata = fifo_data;
        case (state_q)
            IDLE: begin
                if (req && ready) begin
                    addr_d = addr & ALIGN_MASK;
                    cnt_d  = 4'd0;
                    if (rw) begin
                        state_d = WCOLLECT;
                        // A writeback beat presented alongside req is beat 0.
                        if (fifo_wen) begin
                            buf_we = 1'b1;
                            cnt_d  = 4'd1;
                        end
                    end else begin
                        state_d = AR;
                    end
                end
            end
            WCOLLECT: begin
                if (fifo_wen) begin
                    buf_we = 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = AW;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            AW: begin
                if (m_awready) begin
                    state_d = WDATA;
                    cnt_d   = 4'd0;
                end
            end
            WDATA: begin
                if (m_wready) begin
                    if (cnt_q == LAST) begin
                        state_d = BRESP;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            BRESP: begin
                if (m_bvalid) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            AR: begin
                if (m_arready) begin
                    state_d = RDATA;
                    cnt_d   = 4'd0;
                end
            end
            RDATA: begin
                if (m_rvalid) begin
                    buf_we    = 1'b1;
                    buf_wdata = m_rdata;
                    // An early rlast ends the burst; unfilled slots replay stale data.
                    if (m_rlast || cnt_q == LAST) begin
                        state_d = REPLAY;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            REPLAY: begin
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        if (buf_we) begin
            buf_q[idx] <= buf_wdata;
        end
    end

    // The done cycle of a writeback still reads as busy; ready returns one cycle later.
    assign ready     = (state_q == IDLE) && !done_q;
    assign done      = done_q || (state_q == REPLAY);
    assign data_o    = (state_q == REPLAY) ? buf_q[idx] : 64'd0;
    assign beat_idx  = (state_q == REPLAY) ? cnt_q : 4'd0;

    assign m_awaddr  = addr_q;
    assign m_awlen   = 8'(BEATS - 1);
    assign m_awsize  = 3'd3;
    assign m_awburst = 2'b01;
    assign m_awid    = AXI_ID;
    assign m_awvalid = (state_q == AW);

    assign m_wdata   = buf_q[idx];
    assign m_wstrb   = 8'hFF;
    assign m_wlast   = (state_q == WDATA) && (cnt_q == LAST);
    assign m_wvalid  = (state_q == WDATA);
    assign m_bready  = (state_q == BRESP);

    assign m_araddr  = addr_q;
    assign m_arlen   = 8'(BEATS - 1);
    assign m_arsize  = 3'd3;
    assign m_arburst = 2'b01;
    assign m_arid    = AXI_ID;
    assign m_arvalid = (state_q == AR);
    assign m_rready  = (state_q == RDATA);

`ifdef BRIDGE_RESP_CHECK_EN
    logic bus_err_q, bus_err_d;

    always_comb begin
        bus_err_d = bus_err_q
                  | (m_bvalid && m_bready && (m_bresp != 2'b00))
                  | (m_rvalid && m_rready && (m_rresp != 2'b00));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = bus_err_q;
`else
    logic unused_resp;
    assign unused_resp = ^{m_bresp, m_rresp};
    assign bus_err     = 1'b0;
`endif

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge: bench-side AXI memory responder plus a queue-based
// model of expected W beats and refill replay beats, checked on every clock.
module tb_cache_axi_bridge;

    localparam int BEATS = 8;
`ifdef BRIDGE_RESP_CHECK_EN
    localparam bit RESP_CHK = 1'b1;
`else
    localparam bit RESP_CHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, req, rw, fifo_wen;
    logic [63:0] addr, fifo_data;
    logic        ready, done, bus_err;
    logic [63:0] data_o;
    logic [3:0]  beat_idx;
    logic [63:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [7:0]  m_awlen, m_wstrb, m_arlen;
    logic [2:0]  m_awsize, m_arsize;
    logic [1:0]  m_awburst, m_arburst, m_bresp, m_rresp;
    logic [3:0]  m_awid, m_arid;
    logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready;
    logic        m_bvalid, m_bready, m_arvalid, m_arready;
    logic        m_rlast, m_rvalid, m_rready;

    always #5 clk = ~clk;

    cache_axi_bridge #(.BEATS(BEATS), .AXI_ID(4'd0)) dut (
        .clk(clk), .rst(rst), .ready(ready), .req(req), .rw(rw), .addr(addr),
        .fifo_wen(fifo_wen), .fifo_data(fifo_data), .done(done), .data_o(data_o),
        .beat_idx(beat_idx), .bus_err(bus_err),
        .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awburst(m_awburst),
        .m_awid(m_awid), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_arid(m_arid), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid),
        .m_rready(m_rready)
    );

    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_rd[$];
    logic [63:0] exp_w[$];
    int          rd_pos = 0;
    bit          in_replay = 1'b0;
    bit          wdone_ok = 1'b0;
    int          ar_count = 0;
    int          w_hs = 0;
    logic [63:0] rd_words [BEATS];
    logic [63:0] wr_words [BEATS];
    logic        exp_bus_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Model side: every W handshake and every done cycle is matched against the expected queues.
    always @(negedge clk) begin
        if (m_arvalid && m_arready) ar_count++;
        if (m_awvalid || m_arvalid) chk("aw_ar_exclusive", 64'(m_awvalid & m_arvalid), 64'd0);
        if (m_wvalid && m_wready) begin
            if (exp_w.size() == 0) begin
                fail_now("w_extra_beat");
            end else begin
                chk("wdata", m_wdata, exp_w[0]);
                chk("wlast", 64'(m_wlast), 64'(exp_w.size() == 1));
                void'(exp_w.pop_front());
                w_hs++;
            end
        end
        if (done) begin
            if (exp_rd.size() > 0) begin
                chk("replay_data", data_o, exp_rd[0]);
                chk("replay_idx", 64'(beat_idx), 64'(rd_pos));
                void'(exp_rd.pop_front());
                rd_pos++;
                in_replay = (exp_rd.size() != 0);
            end else if (!wdone_ok) begin
                fail_now("unexpected_done");
            end
        end else if (in_replay) begin
            fail_now("replay_gap");
            in_replay = 1'b0;
        end
    end

    task automatic do_refill(input logic [63:0] a, input logic [63:0] exp_araddr,
                             input logic [63:0] first_lit, input int rst_beat,
                             input int err_beat, input bit hold, input bit spur);
        int n;
        int ar_before;
        ar_before = ar_count;
        @(posedge clk); #1;
        req = 1'b1; rw = 1'b0; addr = a;
        @(posedge clk); #1;
        if (!hold) req = 1'b0;
        @(negedge clk);
        chk("ready_low_after_req", 64'(ready), 64'd0);
        n = 0;
        while (!m_arvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!m_arvalid) begin
            fail_now("arvalid_timeout");
            req = 1'b0;
            return;
        end
        chk("araddr", m_araddr, exp_araddr);
        chk("arlen", 64'(m_arlen), 64'd7);
        chk("arsize_burst_id", 64'({m_arsize, m_arburst, m_arid}), 64'({3'd3, 2'b01, 4'd0}));
        @(posedge clk); #1;
        @(negedge clk);
        chk("arvalid_held", 64'({m_arvalid, m_araddr == exp_araddr}), 64'b11);
        @(posedge clk); #1;
        m_arready = 1'b1;
        @(posedge clk); #1;
        m_arready = 1'b0;
        if (rst_beat < 0) begin
            for (int i = 0; i < BEATS; i++) exp_rd.push_back(rd_words[i]);
            rd_pos = 0;
        end
        for (int i = 0; i < BEATS; i++) begin
            m_rvalid = 1'b1;
            m_rdata  = rd_words[i];
            m_rlast  = (i == BEATS - 1);
            m_rresp  = (i == err_beat) ? 2'b10 : 2'b00;
            if (spur && i == 2) begin
                fifo_wen  = 1'b1;
                fifo_data = 64'hDEAD_BEEF_DEAD_BEEF;
            end
            if (i == rst_beat) rst = 1'b1;
            @(negedge clk);
            chk("rready", 64'(m_rready), 64'd1);
            @(posedge clk); #1;
            fifo_wen = 1'b0;
            if (i == rst_beat) begin
                rst = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00; req = 1'b0;
                @(negedge clk);
                chk("rst_ready", 64'(ready), 64'd1);
                chk("rst_rready", 64'(m_rready), 64'd0);
                chk("rst_done", 64'(done), 64'd0);
                return;
            end
        end
        m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00; req = 1'b0;
        @(negedge clk);
        chk("first_replay_done", 64'(done), 64'd1);
        chk("first_replay_idx", 64'(beat_idx), 64'd0);
        chk("first_replay_lit", data_o, first_lit);
        repeat (BEATS) @(negedge clk);
        chk("ready_after_replay", 64'(ready), 64'd1);
        chk("done_after_replay", 64'(done), 64'd0);
        chk("replay_all_emitted", 64'(exp_rd.size()), 64'd0);
        chk("single_ar", 64'(ar_count - ar_before), 64'd1);
    endtask

    task automatic do_writeback(input logic [63:0] a, input logic [63:0] exp_awaddr,
                                input int awdelay, input bit toggle);
        int n;
        w_hs = 0;
        for (int i = 0; i < BEATS; i++) exp_w.push_back(wr_words[i]);
        @(posedge clk); #1;
        req = 1'b1; rw = 1'b1; addr = a;
        fifo_wen = 1'b1; fifo_data = wr_words[0];
        @(posedge clk); #1;
        req = 1'b0;
        for (int i = 1; i < BEATS; i++) begin
            if (i == 4) begin
                fifo_wen = 1'b0;
                @(posedge clk); #1;
            end
            fifo_wen = 1'b1; fifo_data = wr_words[i];
            @(posedge clk); #1;
        end
        fifo_wen = 1'b0;
        @(negedge clk);
        n = 0;
        while (!m_awvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!m_awvalid) begin
            fail_now("awvalid_timeout");
            return;
        end
        chk("awaddr", m_awaddr, exp_awaddr);
        chk("awlen", 64'(m_awlen), 64'd7);
        chk("aw_size_burst_id", 64'({m_awsize, m_awburst, m_awid}), 64'({3'd3, 2'b01, 4'd0}));
        chk("wstrb", 64'(m_wstrb), 64'hFF);
        chk("wvalid_before_aw", 64'(m_wvalid), 64'd0);
        for (int d = 0; d < awdelay; d++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("awvalid_held", 64'({m_awvalid, m_awaddr == exp_awaddr}), 64'b11);
        end
        @(posedge clk); #1;
        m_awready = 1'b1;
        @(posedge clk); #1;
        m_awready = 1'b0;
        n = 0;
        while (w_hs < BEATS && n < 40) begin
            m_wready = toggle ? (n % 2 == 1) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        m_wready = 1'b0;
        chk("w_handshakes", 64'(w_hs), 64'(BEATS));
        @(negedge clk);
        chk("wvalid_after_burst", 64'(m_wvalid), 64'd0);
        chk("bready", 64'(m_bready), 64'd1);
        @(posedge clk); #1;
        wdone_ok = 1'b1;
        m_bvalid = 1'b1; m_bresp = 2'b00;
        @(posedge clk); #1;
        m_bvalid = 1'b0;
        @(negedge clk);
        chk("write_done", 64'(done), 64'd1);
        chk("ready_during_done", 64'(ready), 64'd0);
        @(negedge clk);
        chk("write_done_single", 64'(done), 64'd0);
        chk("ready_after_write", 64'(ready), 64'd1);
        wdone_ok = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 1'b0; rw = 1'b0; addr = 64'd0; fifo_wen = 1'b0; fifo_data = 64'd0;
        m_awready = 1'b0; m_wready = 1'b0; m_bresp = 2'b00; m_bvalid = 1'b0;
        m_arready = 1'b0; m_rdata = 64'd0; m_rresp = 2'b00; m_rlast = 1'b0; m_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", 64'(ready), 64'd1);
        chk("reset_valids", 64'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}), 64'd0);
        chk("reset_done_err", 64'({done, bus_err}), 64'd0);
        chk("reset_data_o", data_o, 64'd0);
        chk("reset_beat_idx", 64'(beat_idx), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < BEATS; i++) rd_words[i] = 64'h11 * 64'(i + 1);
        do_refill(64'h8000_1234, 64'h8000_1200, 64'h11, -1, -1, 1'b0, 1'b0);

        for (int i = 0; i < BEATS; i++) wr_words[i] = 64'hA0 + 64'(i);
        do_writeback(64'h8000_0040, 64'h8000_0040, 3, 1'b0);

        for (int i = 0; i < BEATS; i++) wr_words[i] = 64'hCAFE_0000_0000_0000 | 64'(i * 3);
        do_writeback(64'h1234_5678_9ABC_DEF7, 64'h1234_5678_9ABC_DEC0, 0, 1'b1);

        for (int i = 0; i < BEATS; i++) rd_words[i] = 64'h5000 + 64'(i);
        do_refill(64'h0000_0000_0000_0100, 64'h100, 64'h5000, 4, -1, 1'b0, 1'b0);

        for (int i = 0; i < BEATS; i++) rd_words[i] = 64'h1000 + 64'(i);
        do_refill(64'h0000_0000_0000_0047, 64'h40, 64'h1000, -1, -1, 1'b0, 1'b0);
        chk("bus_err_clean", 64'(bus_err), 64'd0);

        for (int i = 0; i < BEATS; i++) rd_words[i] = 64'h6000 + 64'(i);
        do_refill(64'h0000_0001_0000_0080, 64'h1_0000_0080, 64'h6000, -1, 3, 1'b0, 1'b0);
        exp_bus_err = RESP_CHK;
        chk("bus_err_after_rresp", 64'(bus_err), 64'(exp_bus_err));

        for (int i = 0; i < BEATS; i++) wr_words[i] = 64'h7700 + 64'(i);
        do_writeback(64'h0000_0000_0000_0200, 64'h200, 1, 1'b0);
        chk("bus_err_sticky", 64'(bus_err), 64'(exp_bus_err));

        for (int i = 0; i < BEATS; i++) rd_words[i] = 64'hF0F0_0000 + 64'(i * 17);
        do_refill(64'hFFFF_FFFF_FFFF_FFC5, 64'hFFFF_FFFF_FFFF_FFC0, 64'hF0F0_0000, -1, -1, 1'b1, 1'b1);
        chk("bus_err_final", 64'(bus_err), 64'(exp_bus_err));

        repeat (3) @(negedge clk);
        chk("idle_at_end", 64'({ready, m_arvalid, m_awvalid}), 64'b100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
